// File: rtl/vga_pkg.sv
// Shared constants for the VGA drawing engines: geometry, colour layout, FSM encoding.
package vga_pkg;

    localparam int nX          = 8;
    localparam int nY          = 7;
    localparam int COLOR_DEPTH = 6;
    localparam int COLS        = 160;
    localparam int ROWS        = 120;

    // Colour word is {R,G,B}, each channel CH_W bits, R in the MSBs.
    localparam int CH_W  = COLOR_DEPTH / 3;
    localparam int R_LSB = 2 * CH_W;
    localparam int G_LSB = CH_W;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } fill_state_e;

    function automatic logic [COLOR_DEPTH-1:0] pack_rgb(
        input logic [CH_W-1:0] r,
        input logic [CH_W-1:0] g,
        input logic [CH_W-1:0] b
    );
        logic [COLOR_DEPTH-1:0] c;
        c = '0;
        c[R_LSB +: CH_W] = r;
        c[G_LSB +: CH_W] = g;
        c[B_LSB +: CH_W] = b;
        return c;
    endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// One axis of a raster walk: counts 0..extent-1, wrapping to 0 on a step taken at the last index.
module vga_raster_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] extent,
    input  logic         step,
    input  logic         clear,
    output logic [W-1:0] index,
    output logic         last
);

    logic [W-1:0] index_q;
    logic [W-1:0] index_d;

    assign last  = (index_q == (extent - W'(1)));
    assign index = index_q;

    always_comb begin
        index_d = index_q;
        if (clear) begin
            index_d = '0;
        end else if (step) begin
            index_d = last ? '0 : (index_q + W'(1));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine feeding the video memory write port, one pixel per clock in raster order.
// Optional build macro VGA_RECT_CLIP_EN clips each command to the visible COLS x ROWS area.
module vga_rect_filler
    import vga_pkg::*;
(
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [nX-1:0]          x0,
    input  logic [nY-1:0]          y0,
    input  logic [nX-1:0]          w,
    input  logic [nY-1:0]          h,
    input  logic [COLOR_DEPTH-1:0] colour,
    output logic                   busy,
    output logic                   done,
    output logic [nX-1:0]          x_out,
    output logic [nY-1:0]          y_out,
    output logic [COLOR_DEPTH-1:0] colour_out,
    output logic                   plot
);

    fill_state_e state_q, state_d;

    logic [nX-1:0]          x0_q, x0_d;
    logic [nY-1:0]          y0_q, y0_d;
    logic [nX-1:0]          w_q, w_d;
    logic [nY-1:0]          h_q, h_d;
    logic [COLOR_DEPTH-1:0] col_q, col_d;

    // Last emitted pixel, so the write-port address/data hold steady between commands.
    logic [nX-1:0]          last_x_q, last_x_d;
    logic [nY-1:0]          last_y_q, last_y_d;
    logic [COLOR_DEPTH-1:0] last_col_q, last_col_d;

    logic [nX-1:0] w_eff;
    logic [nY-1:0] h_eff;
    logic          accept;
    logic          in_fill;
    logic [nX-1:0] xi;
    logic [nY-1:0] yi;
    logic          x_last;
    logic          y_last;
    logic [nX-1:0] pix_x;
    logic [nY-1:0] pix_y;

    assign accept  = (state_q == IDLE) && start;
    assign in_fill = (state_q == FILL);
    assign pix_x   = x0_q + xi;
    assign pix_y   = y0_q + yi;

`ifdef VGA_RECT_CLIP_EN
    localparam logic [nX:0] COLS_L = (nX+1)'(COLS);
    localparam logic [nY:0] ROWS_L = (nY+1)'(ROWS);

    logic [nX:0] x_room;
    logic [nY:0] y_room;

    assign x_room = COLS_L - {1'b0, x0};
    assign y_room = ROWS_L - {1'b0, y0};

    always_comb begin
        if ({1'b0, x0} >= COLS_L) begin
            w_eff = '0;
        end else if ({1'b0, w} < x_room) begin
            w_eff = w;
        end else begin
            w_eff = x_room[nX-1:0];
        end

        if ({1'b0, y0} >= ROWS_L) begin
            h_eff = '0;
        end else if ({1'b0, h} < y_room) begin
            h_eff = h;
        end else begin
            h_eff = y_room[nY-1:0];
        end
    end
`else
    assign w_eff = w;
    assign h_eff = h;
`endif

    vga_raster_counter #(.W(nX)) u_col_counter (
        .clock  (clock),
        .resetn (resetn),
        .extent (w_q),
        .step   (in_fill),
        .clear  (accept),
        .index  (xi),
        .last   (x_last)
    );

    vga_raster_counter #(.W(nY)) u_row_counter (
        .clock  (clock),
        .resetn (resetn),
        .extent (h_q),
        .step   (in_fill && x_last),
        .clear  (accept),
        .index  (yi),
        .last   (y_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            last_x_q   <= '0;
            last_y_q   <= '0;
            last_col_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            last_col_q <= last_col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ((w_eff == '0) || (h_eff == '0)) ? FIN : FILL;
                end
            end
            FILL: begin
                if (x_last && y_last) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_col_d = last_col_q;
        if (accept) begin
            x0_d  = x0;
            y0_d  = y0;
            w_d   = w_eff;
            h_d   = h_eff;
            col_d = colour;
        end
        if (in_fill) begin
            last_x_d   = pix_x;
            last_y_d   = pix_y;
            last_col_d = col_q;
        end
    end

    always_comb begin
        plot       = in_fill;
        busy       = in_fill;
        done       = (state_q == FIN);
        x_out      = in_fill ? pix_x : last_x_q;
        y_out      = in_fill ? pix_y : last_y_q;
        colour_out = in_fill ? col_q : last_col_q;
    end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Self-checking bench for vga_rect_filler; honours VGA_RECT_CLIP_EN in its reference model.
module tb_vga_rect_filler;
    import vga_pkg::*;

    logic                   clock  = 1'b0;
    logic                   resetn = 1'b1;
    logic                   start  = 1'b0;
    logic [nX-1:0]          x0     = '0;
    logic [nY-1:0]          y0     = '0;
    logic [nX-1:0]          w      = '0;
    logic [nY-1:0]          h      = '0;
    logic [COLOR_DEPTH-1:0] colour = '0;
    logic                   busy;
    logic                   done;
    logic [nX-1:0]          x_out;
    logic [nY-1:0]          y_out;
    logic [COLOR_DEPTH-1:0] colour_out;
    logic                   plot;

    int checks = 0;
    int errors = 0;
    int last_x = 0;
    int last_y = 0;
    int last_c = 0;

    vga_rect_filler dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .colour     (colour),
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    always #5 clock = ~clock;

    function automatic int eff_extent(int org, int ext, int lim);
`ifdef VGA_RECT_CLIP_EN
        if (org >= lim) return 0;
        return (ext < lim - org) ? ext : (lim - org);
`else
        return ext;
`endif
    endfunction

    task automatic check(string tag, logic [23:0] obs, logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits one clock, then compares {plot,busy,done,x,y,colour}; xy=0 masks the pixel fields.
    task automatic tick(string tag, bit p, bit b, bit d, bit xy, int ex, int ey, int ec);
        logic [23:0] o;
        logic [23:0] e;
        @(negedge clock);
        o = {plot, busy, done,
             xy ? x_out : 8'h00, xy ? y_out : 7'h00, xy ? colour_out : 6'h00};
        e = {p, b, d,
             xy ? 8'(ex) : 8'h00, xy ? 7'(ey) : 7'h00, xy ? 6'(ec) : 6'h00};
        $display("cycle %s: plot=%0d busy=%0d done=%0d x=%0d y=%0d c=%h", tag,
                 plot, busy, done, x_out, y_out, colour_out);
        check(tag, o, e);
    endtask

    task automatic run_cmd(int ax, int ay, int aw, int ah, int ac,
                           bit hold, bit pre_idle, bit ign, string tag);
        int we;
        int he;
        int k;
        x0     = 8'(ax);
        y0     = 7'(ay);
        w      = 8'(aw);
        h      = 7'(ah);
        colour = 6'(ac);
        start  = 1'b1;
        if (pre_idle) tick({tag, " gap"}, 0, 0, 0, 1, last_x, last_y, last_c);
        we = eff_extent(ax, aw, COLS);
        he = eff_extent(ay, ah, ROWS);
        k  = 0;
        for (int yy = 0; yy < he; yy++) begin
            for (int xx = 0; xx < we; xx++) begin
                tick({tag, " write"}, 1, 1, 0, 1, (ax + xx) % 256, (ay + yy) % 128, ac);
                last_x = (ax + xx) % 256;
                last_y = (ay + yy) % 128;
                last_c = ac;
                if (!hold && k == 0) start = 1'b0;
                if (ign && k == 0) begin
                    start  = 1'b1;
                    x0     = 8'($urandom);
                    y0     = 7'($urandom);
                    w      = 8'($urandom_range(1, 5));
                    h      = 7'($urandom_range(1, 5));
                    colour = ~6'(ac);
                end
                if (ign && k == 1) start = 1'b0;
                k++;
            end
        end
        tick({tag, " done"}, 0, 0, 1, 0, 0, 0, 0);
        if (!hold) begin
            start = 1'b0;
            tick({tag, " idle"}, 0, 0, 0, 1, last_x, last_y, last_c);
        end
    endtask

    initial begin
        #1 resetn = 1'b0;
        #1 check("reset state", {plot, busy, done, x_out, y_out, colour_out}, 24'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        tick("post-reset idle", 0, 0, 0, 1, 0, 0, 0);

        // Reset abandons a fill in progress after five writes.
        x0 = 8'd10; y0 = 7'd5; w = 8'd4; h = 7'd3; colour = pack_rgb(2'b11, 2'b00, 2'b00);
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick("midreset write", 1, 1, 0, 1, 10 + k % 4, 5 + k / 4, 6'b110000);
            start = 1'b0;
        end
        #2 resetn = 1'b0;
        #1 check("reset mid-fill", {plot, busy, done, x_out, y_out, colour_out}, 24'h0);
        @(negedge clock);
        resetn = 1'b1;
        last_x = 0; last_y = 0; last_c = 0;
        repeat (3) tick("after reset", 0, 0, 0, 1, 0, 0, 0);

        run_cmd(10, 5, 4, 3, pack_rgb(2'b11, 2'b00, 2'b00), 0, 0, 0, "basic");
        run_cmd(20, 20, 0, 7, pack_rgb(2'b01, 2'b10, 2'b11), 0, 0, 0, "empty");
        run_cmd(30, 30, 2, 2, pack_rgb(2'b00, 2'b11, 2'b00), 0, 0, 1, "ignored");
        tick("ignored no-requeue", 0, 0, 0, 1, last_x, last_y, last_c);

        run_cmd(1, 1, 1, 1, pack_rgb(2'b10, 2'b00, 2'b01), 1, 0, 0, "b2b0");
        run_cmd(2, 1, 1, 1, pack_rgb(2'b01, 2'b01, 2'b01), 1, 1, 0, "b2b1");
        run_cmd(3, 1, 1, 1, pack_rgb(2'b00, 2'b00, 2'b11), 0, 1, 0, "b2b2");

        run_cmd(158, 119, 4, 2, pack_rgb(2'b11, 2'b11, 2'b00), 0, 0, 0, "edge");

        for (int n = 0; n < 20; n++) begin
            run_cmd($urandom_range(0, 255), $urandom_range(0, 127),
                    $urandom_range(0, 6), $urandom_range(0, 4),
                    $urandom_range(0, 63), 0, 0, 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
